// File: rtl/serial_rx.sv
// serial_rx: oversampled asynchronous serial receiver.
// Deserialises an idle-high, LSB-first line (start + WIDTH data + stop) into
// WIDTH-bit words and offers them on a valid/ready output port.
// Optional build macro: SERIAL_RX_PARITY_EN adds one even-parity bit between
// the data bits and the stop bit, plus a parity_err pulse output.
//
// Output handshake: valid stays high while data_out holds an unread word; the
// word is consumed on any rising clk edge where valid && ready. A word that
// completes while valid && !ready is dropped and flagged by a one-cycle
// overrun pulse. ready only feeds registers, never an output directly.
module serial_rx #(
    parameter int WIDTH = 9,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             frame_err,
`ifdef SERIAL_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            sync1, rxd_s;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH:0]  shift_in;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // New bit enters at the MSB; the oldest bit ends up at bit 0 (LSB-first).
    assign shift_in = {rxd_s, sreg_q};

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    // Receiver state, timing counters, shift register and end-of-frame pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sreg_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sreg_q  <= sreg_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state logic: mid-bit sampling driven by the bit-period counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        sreg_d  = sreg_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxd_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit half a bit period in; a high line is a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
`ifdef SERIAL_RX_PARITY_EN
                    par_d = 1'b0;
`endif
                    state_d = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    sreg_d = shift_in[WIDTH:1];
                    idx_d  = idx_q + IW'(1);
`ifdef SERIAL_RX_PARITY_EN
                    par_d  = par_q ^ rxd_s;
`endif
                    if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                // Even parity: XOR of data bits and parity bit must come out 0.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = par_q ^ rxd_s;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (par_q) begin
                            perr_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
`else
                        done_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Stay here through a break so a long low line is not a new start bit.
                cnt_d = '0;
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output register: load a finished word, drop it on overrun, clear on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= ferr_q;
            overrun   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err <= perr_q;
`endif
            if (done_q) begin
                if (!valid || ready) begin
                    data_out <= sreg_q;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/serial_rx.md
# serial_rx

Oversampled asynchronous serial receiver. Deserialises an idle-high, LSB-first serial line into WIDTH-bit words and presents them on a valid/ready output port. It is the receiving end of the team's serial transmitter and sits between an external pin (through the team's pullup/pulldown primitives) and a word-level consumer. Its behavioural RTL uses shifts, case, always_ff and always_comb, so it also serves as an elaboration and simulation regression for those constructs.

## Interface
- WIDTH, 9: data bits per frame (1..32).
- DIV, 4: clock cycles per bit period; must be even and ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  WIDTH  received word; reset 0.
- valid  output  1  data_out holds an unread word; reset 0.
- ready  input  1  consumer accepts the word when valid && ready.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low; reset 0.
- overrun  output  1  one-cycle pulse when a word is dropped; reset 0.

## Operation
- rxd passes through a 2-flop synchroniser (rxd_s). Both flops reset to 1.
- The receiver FSM has states IDLE, START, DATA, STOP and WAIT_HIGH. Reset state is IDLE.
- IDLE: when rxd_s==0, go to START and clear the bit-period counter.
- START: after DIV/2 cycles, sample rxd_s.
  - rxd_s==1 (glitch): go to IDLE with no error.
  - rxd_s==0: go to DATA with bit index 0.
- DATA: sample rxd_s every DIV cycles. Shift it in LSB-first: sreg = {rxd_s, sreg[WIDTH-1:1]}. Leave for STOP after WIDTH samples.
- STOP: sample rxd_s after DIV cycles.
  - rxd_s==1: the word is complete. Go to IDLE.
  - rxd_s==0: pulse frame_err, discard the word, go to WAIT_HIGH.
- WAIT_HIGH: go to IDLE once rxd_s==1. This covers break conditions and prevents false restarts.
- Output register:
  - A completed word loads data_out and sets valid on the next cycle if valid==0, or if valid && ready in the same cycle.
  - A completed word while valid && !ready is dropped: overrun pulses, and data_out and valid are unchanged.
  - valid clears on valid && ready when no new word completes in that cycle.
- The counter and bit index are wide enough for DIV-1 and WIDTH. No wrap is visible at the interface.
- When rst asserts mid-frame, the FSM returns to IDLE immediately, all outputs go to their reset values, and the partial word is lost.

## Timing
- rxd first sampled low at edge 0 → valid rises at edge 2 + DIV/2 + (WIDTH+1)·DIV + 1.
  - Default parameters: edge 45.
  - With parity enabled (see Configuration), add DIV.
- frame_err rises on the edge after the stop sample, at the same cycle position where valid would have risen.
- A new start bit is recognised in the first IDLE cycle, so back-to-back frames with a single stop bit are received without loss.
- ready has no combinational path to any output.

## Configuration
- SERIAL_RX_PARITY_EN defined:
  - The FSM gains a PARITY state between DATA and STOP that samples one even-parity bit after DIV cycles.
  - A parity_err output (1 bit, reset 0) is added. It pulses one cycle when the XOR of the data bits and the parity bit is 1. It rises on the same edge valid would rise.
  - A word with a parity error is discarded and does not set valid.
- SERIAL_RX_PARITY_EN undefined: there is no PARITY state and no parity_err port. The frame is start + WIDTH data bits + stop.

## Test plan
- Reset mid-frame: after 20 cycles into a frame of 9'h1A5, assert rst → all outputs 0, FSM IDLE. Then a clean frame of 9'h0FF → data_out=9'h0FF, valid at edge 45.
- Single frame 9'h1A5, ready held 1 → data_out=9'h1A5, valid high for exactly one cycle at edge 45, frame_err=0, overrun=0.
- Glitch: rxd low for 1 cycle, then high → no state beyond START, no valid, no frame_err.
- Frame 9'h055 with stop bit forced low, then line held low 30 cycles → frame_err pulses once, valid stays 0, next frame 9'h003 is received correctly after the line returns high.
- Overrun: frames 9'h111 then 9'h122 back-to-back with ready=0 → data_out stays 9'h111, overrun pulses once. Then with ready=1 in the cycle 9'h133 completes → data_out=9'h133, no overrun.
- SERIAL_RX_PARITY_EN: 9'h1A5 (five ones) with parity bit 1 → valid, data_out=9'h1A5. Same frame with parity bit 0 → parity_err pulse, valid stays 0.
